// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised FIFO: occupancy counter sizing.
package sync_fifo_pkg;

   // Width needed to hold an occupancy value in 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer over 0..DEPTH-1 with explicit wrap, so DEPTH need not be a power of two.
module fifo_wrap_ptr #(
   parameter  int DEPTH = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock elastic FIFO with occupancy count, programmable level flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 8,
   parameter  int AF_LEVEL = DEPTH - 1,
   parameter  int AE_LEVEL = 1,
   localparam int CW       = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop_acc;
   logic             push_acc;
   logic             ovf_event;
   logic             unf_event;

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   // Flush overrides everything, including error detection.
   assign pop_acc   = pop && !empty && !flush;
   assign push_acc  = push && !flush && (!full || pop_acc);
   assign ovf_event = push && !flush && !push_acc;
   assign unf_event = pop && !flush && empty;

   assign data_out = empty ? '0 : mem[rd_ptr];

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (push_acc),
      .ptr   (wr_ptr)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (pop_acc),
      .ptr   (rd_ptr)
   );

   // Storage is intentionally left out of reset; empty masks stale contents.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push_acc && !pop_acc) begin
         count <= count + 1'b1;
      end else if (pop_acc && !push_acc) begin
         count <= count - 1'b1;
      end
   end

   // A fresh error event wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_event || (overflow && !clr_err);
         underflow <= unf_event || (underflow && !clr_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param with WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_sync_fifo_param;

   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic             flush = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             empty, full, almost_full, almost_empty, overflow, underflow;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;
   logic [WIDTH-1:0] exp_d;

   sync_fifo_param #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
      .clr_err(clr_err), .data_in(data_in), .data_out(data_out), .count(count),
      .empty(empty), .full(full), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the reference queue tracks what the FIFO should hold.
   task automatic step(input logic p, input logic q, input logic f, input logic c,
                       input logic [WIDTH-1:0] d);
      logic pop_ok, push_ok;
      push = p; pop = q; flush = f; clr_err = c; data_in = d;
      pop_ok  = q && (sb.size() > 0) && !f;
      push_ok = p && !f && ((sb.size() < DEPTH) || pop_ok);
      m_ovf = (p && !f && !push_ok) || (m_ovf && !c);
      m_unf = (q && !f && (sb.size() == 0)) || (m_unf && !c);
      if (f) sb.delete();
      else begin
         if (pop_ok) void'(sb.pop_front());
         if (push_ok) sb.push_back(d);
      end
      @(posedge clk); #1;
      $display("txn push=%0b pop=%0b flush=%0b clr=%0b din=%02h -> count=%0d dout=%02h ovf=%0b unf=%0b",
               p, q, f, c, d, count, data_out, overflow, underflow);
      push = 0; pop = 0; flush = 0; clr_err = 0;
   endtask

   function automatic logic [WIDTH-1:0] head();
      return (sb.size() > 0) ? sb[0] : '0;
   endfunction

   task automatic test_reset();
      rst_n = 0; #3;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%0b%0b exp=10", empty, full); end
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost got=%0b%0b exp=10", almost_empty, almost_full); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b%0b exp=00", overflow, underflow); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%02h exp=00", data_out); end
      sb.delete(); m_ovf = 0; m_unf = 0;
      @(negedge clk); rst_n = 1; @(negedge clk);
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 8'(8'h11 * i));
      checks++; if (count !== 3'd5 || full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0d/%0b exp=5/1", count, full); end
      checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL fill_head got=%02h exp=11", data_out); end
      step(1, 0, 0, 0, 8'h66);
      checks++; if (count !== 3'd5 || overflow !== 1'b1) begin failures++; $display("FAIL overflow got=%0d/%0b exp=5/1", count, overflow); end
      checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL overflow_head got=%02h exp=11", data_out); end
   endtask

   task automatic test_drain_underflow();
      for (int i = 1; i <= 5; i++) begin
         exp_d = head();
         checks++; if (data_out !== exp_d || exp_d !== 8'(8'h11 * i)) begin failures++; $display("FAIL drain_%0d got=%02h exp=%02h", i, data_out, 8'(8'h11 * i)); end
         step(0, 1, 0, 0, 8'h00);
      end
      checks++; if (empty !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL drained got=%0b/%02h exp=1/00", empty, data_out); end
      step(0, 1, 0, 0, 8'h00);
      checks++; if (underflow !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL underflow got=%0b/%0d exp=1/0", underflow, count); end
   endtask

   task automatic test_wrap();
      step(0, 0, 0, 1, 8'h00);
      for (int k = 0; k < 12; k++) begin
         if ((k % 4) < 2) step(1, 0, 0, 0, 8'($urandom_range(1, 255)));
         else begin
            exp_d = head();
            checks++; if (data_out !== exp_d) begin failures++; $display("FAIL wrap_data_%0d got=%02h exp=%02h", k, data_out, exp_d); end
            step(0, 1, 0, 0, 8'h00);
         end
         checks++; if (count !== CW'(sb.size())) begin failures++; $display("FAIL wrap_count_%0d got=%0d exp=%0d", k, count, sb.size()); end
      end
   endtask

   task automatic test_push_pop_full_empty();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'hA0 + i));
      step(1, 1, 0, 0, 8'hA5);
      checks++; if (count !== 3'd5 || overflow !== 1'b0) begin failures++; $display("FAIL pp_full got=%0d/%0b exp=5/0", count, overflow); end
      checks++; if (data_out !== 8'hA1 || data_out !== head()) begin failures++; $display("FAIL pp_full_head got=%02h exp=a1", data_out); end
      while (sb.size() > 0) begin
         exp_d = head();
         checks++; if (data_out !== exp_d) begin failures++; $display("FAIL pp_drain got=%02h exp=%02h", data_out, exp_d); end
         step(0, 1, 0, 0, 8'h00);
      end
      step(0, 0, 0, 1, 8'h00);
      step(1, 1, 0, 0, 8'h3C);
      checks++; if (count !== 3'd1 || underflow !== 1'b1) begin failures++; $display("FAIL pp_empty got=%0d/%0b exp=1/1", count, underflow); end
      checks++; if (data_out !== 8'h3C) begin failures++; $display("FAIL pp_empty_head got=%02h exp=3c", data_out); end
   endtask

   task automatic test_levels();
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL lvl_1 got=%0b%0b exp=10", almost_empty, almost_full); end
      step(1, 0, 0, 0, 8'h42);
      checks++; if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL lvl_2 got=%0b%0b exp=00", almost_empty, almost_full); end
      step(1, 0, 0, 0, 8'h43);
      checks++; if (almost_empty !== 1'b0 || almost_full !== 1'b0 || count !== 3'd3) begin failures++; $display("FAIL lvl_3 got=%0b%0b/%0d exp=00/3", almost_empty, almost_full, count); end
      step(1, 0, 0, 0, 8'h44);
      checks++; if (almost_full !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL lvl_4 got=%0b%0b exp=10", almost_full, full); end
   endtask

   task automatic test_flush_clr();
      step(1, 0, 0, 0, 8'h45);
      step(1, 0, 0, 0, 8'h46);
      step(0, 1, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      checks++; if (count !== 3'd3 || overflow !== m_ovf || !m_ovf) begin failures++; $display("FAIL pre_flush got=%0d/%0b exp=3/1", count, overflow); end
      step(1, 0, 1, 0, 8'h99);
      checks++; if (count !== 3'd0 || empty !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL flush got=%0d/%0b/%02h exp=0/1/00", count, empty, data_out); end
      checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin failures++; $display("FAIL flush_keeps_err got=%0b%0b exp=11", overflow, underflow); end
      step(0, 0, 0, 1, 8'h00);
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL clr_err got=%0b%0b exp=00", overflow, underflow); end
      step(0, 1, 0, 1, 8'h00);
      checks++; if (underflow !== 1'b1 || overflow !== m_ovf) begin failures++; $display("FAIL clr_set_wins got=%0b%0b exp=01", overflow, underflow); end
   endtask

   task automatic test_reset_mid();
      step(1, 0, 0, 0, 8'h71);
      step(1, 0, 0, 0, 8'h72);
      push = 1; data_in = 8'h73; #2;
      rst_n = 0; #1;
      checks++; if (count !== 3'd0 || empty !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL mid_reset got=%0d/%0b/%02h exp=0/1/00", count, empty, data_out); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || almost_empty !== 1'b1) begin failures++; $display("FAIL mid_reset_flags got=%0b%0b%0b exp=001", overflow, underflow, almost_empty); end
      push = 0;
      sb.delete(); m_ovf = 0; m_unf = 0;
      @(negedge clk); rst_n = 1;
      step(1, 0, 0, 0, 8'h5A);
      checks++; if (count !== 3'd1 || data_out !== 8'h5A) begin failures++; $display("FAIL post_reset got=%0d/%02h exp=1/5a", count, data_out); end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_wrap();
      test_push_pop_full_empty();
      test_levels();
      test_flush_clr();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
